// File: rtl/decrypt_pkg.sv
// Shared constants, select codes and FSM encodings for the
// decryption engine routing logic.
package decrypt_pkg;

    localparam int         DEF_D_WIDTH = 8;
    localparam logic [7:0] DEF_TOKEN   = 8'hFA;

    localparam logic [1:0] SEL_CAESAR  = 2'd0;
    localparam logic [1:0] SEL_SCYTALE = 2'd1;
    localparam logic [1:0] SEL_ZIGZAG  = 2'd2;
    localparam logic [1:0] SEL_NONE    = 2'd3;

    typedef enum logic {
        W_IDLE,
        W_MSG
    } w_state_t;

    typedef enum logic [1:0] {
        R_SEND,
        R_WAIT_RISE,
        R_WAIT_FALL
    } r_state_t;

    function automatic logic [2:0] sel_onehot(input logic [1:0] sel);
        logic [2:0] oh;
        oh = 3'b000;
        unique case (sel)
            SEL_CAESAR:  oh = 3'b001;
            SEL_SCYTALE: oh = 3'b010;
            SEL_ZIGZAG:  oh = 3'b100;
            default:     oh = 3'b000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/decryption_demux_sync_fifo.sv
// Show-ahead synchronous FIFO; push when full and pop when
// empty are ignored.
module sync_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/decryption_demux.sv
// Routes buffered messages to one of three decryption engines and
// holds off after each start-decode token until that engine is done.
module decryption_demux
    import decrypt_pkg::*;
#(
    parameter int D_WIDTH = DEF_D_WIDTH,
    parameter int FIFO_DEPTH = 16,
    parameter logic [D_WIDTH-1:0] START_DECRYPTION_TOKEN = D_WIDTH'(DEF_TOKEN),
    parameter int RISE_TIMEOUT = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [D_WIDTH-1:0] data_i,
    input  logic               valid_i,
    input  logic [1:0]         select_i,
    input  logic [2:0]         busy_i,
    output logic [D_WIDTH-1:0] data_o,
    output logic [2:0]         valid_o,
    output logic               full_o,
    output logic               overflow_o
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int TW = $clog2(RISE_TIMEOUT + 1);

    w_state_t w_state_q, w_state_d;
    r_state_t r_state_q, r_state_d;

    logic [1:0]         sel_q, sel_d, cur_sel;
    logic [1:0]         tsel_q, tsel_d;
    logic [TW-1:0]      tmr_q, tmr_d;
    logic               ovf_q, ovf_d;
    logic [D_WIDTH-1:0] data_q, data_d;
    logic [2:0]         valid_q, valid_d;

    logic                 push, pop;
    logic                 fifo_full, fifo_empty;
    logic [D_WIDTH+1:0]   head;
    logic [CW-1:0]        fifo_count;
    logic [1:0]           head_sel;
    logic [D_WIDTH-1:0]   head_chr;
    logic [3:0]           busy_x;

    assign head_sel = head[D_WIDTH+1:D_WIDTH];
    assign head_chr = head[D_WIDTH-1:0];
    assign busy_x   = {1'b0, busy_i};

    sync_fifo #(
        .WIDTH (D_WIDTH + 2),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .wdata ({cur_sel, data_i}),
        .rdata (head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Message tracking continues even for discarded or dropped chars.
    always_comb begin
        w_state_d = w_state_q;
        sel_d     = sel_q;
        cur_sel   = sel_q;
        push      = 1'b0;
        ovf_d     = ovf_q;
        if (valid_i) begin
            if (w_state_q == W_IDLE) begin
                cur_sel = select_i;
                sel_d   = select_i;
            end
            if (cur_sel != SEL_NONE) begin
                if (fifo_full) ovf_d = 1'b1;
                else           push  = 1'b1;
            end
            w_state_d = (data_i == START_DECRYPTION_TOKEN) ? W_IDLE : W_MSG;
        end
    end

    always_comb begin
        r_state_d = r_state_q;
        tsel_d    = tsel_q;
        tmr_d     = tmr_q;
        pop       = 1'b0;
        valid_d   = 3'b000;
        data_d    = data_q;
        case (r_state_q)
            R_SEND: begin
                if (!fifo_empty && !busy_x[head_sel]) begin
                    pop     = 1'b1;
                    data_d  = head_chr;
                    valid_d = sel_onehot(head_sel);
                    if (head_chr == START_DECRYPTION_TOKEN) begin
                        tsel_d    = head_sel;
                        tmr_d     = '0;
                        r_state_d = R_WAIT_RISE;
                    end
                end
            end
            R_WAIT_RISE: begin
                if (busy_x[tsel_q])
                    r_state_d = R_WAIT_FALL;
                else if (tmr_q == TW'(RISE_TIMEOUT - 1))
                    r_state_d = R_SEND;
                else
                    tmr_d = tmr_q + 1'b1;
            end
            R_WAIT_FALL: begin
                if (!busy_x[tsel_q]) r_state_d = R_SEND;
            end
            default: r_state_d = R_SEND;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state_q <= W_IDLE;
            r_state_q <= R_SEND;
            sel_q     <= SEL_CAESAR;
            tsel_q    <= SEL_CAESAR;
            tmr_q     <= '0;
            ovf_q     <= 1'b0;
            data_q    <= '0;
            valid_q   <= 3'b000;
        end else begin
            w_state_q <= w_state_d;
            r_state_q <= r_state_d;
            sel_q     <= sel_d;
            tsel_q    <= tsel_d;
            tmr_q     <= tmr_d;
            ovf_q     <= ovf_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
        end
    end

    assign data_o     = data_q;
    assign valid_o    = valid_q;
    assign full_o     = fifo_full;
    assign overflow_o = ovf_q;

endmodule
